req_dispatcher: RTL and testbench

REQ_DISPATCHER -- requirements
Module: req_dispatcher

---
 rtl/req_dispatcher.sv | 242 ++++++++++++++++++++++++
 tb/tb_req_dispatcher.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_dispatcher.sv
// Arbitrates between the alloc and free request FIFOs, validates page counts and issues one
// request at a time to the fdt (allocs) or the or-tree (frees), or writes a failure response.
module req_dispatcher #(
    parameter int unsigned ID_W           = 8,
    parameter int unsigned IDX_W          = 16,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned MAX_PAGES      = 8,
    parameter int unsigned FREE_THRESHOLD = 256,
    parameter int unsigned ALLOC_BURST    = 4,
    parameter int unsigned SETTLE_CYCLES  = 5,
    parameter int unsigned DCNT_W         = 10,
    parameter int unsigned SZ_W           = $clog2($clog2(MAX_PAGES) + 1)
) (
    input  logic              clk,
    input  logic              rst,

    output logic              alloc_req_pop,
    input  logic [ID_W-1:0]   alloc_req_id,
    input  logic [CNT_W-1:0]  alloc_req_page_count,
    input  logic              alloc_fifo_empty,

    output logic              free_req_pop,
    input  logic [ID_W-1:0]   free_req_id,
    input  logic [IDX_W-1:0]  free_req_page_idx,
    input  logic [CNT_W-1:0]  free_req_page_count,
    input  logic              free_fifo_empty,
    input  logic [DCNT_W-1:0] free_fifo_data_count,

    output logic              alloc_req_valid_fdt_out,
    output logic [ID_W-1:0]   alloc_req_id_fdt_out,
    output logic [SZ_W-1:0]   alloc_req_size_fdt_out,
    input  logic              fdt_blocked_fdt_in,

    output logic              free_req_valid_or_tree_out,
    output logic [ID_W-1:0]   free_req_id_or_tree_out,
    output logic [IDX_W-1:0]  free_req_page_idx_or_tree_out,
    output logic [SZ_W-1:0]   free_req_size_or_tree_out,

    output logic              alloc_rsp_write_en,
    output logic [ID_W-1:0]   alloc_rsp_id,
    output logic              alloc_rsp_fail,
    output logic [1:0]        alloc_rsp_fail_reason,
    input  logic              alloc_rsp_fifo_almost_full,

    output logic              free_rsp_write_en,
    output logic [ID_W-1:0]   free_rsp_id,
    output logic              free_rsp_fail,
    output logic [1:0]        free_rsp_fail_reason,
    input  logic              free_rsp_fifo_almost_full,

    output logic              busy
);

    localparam logic [CNT_W-1:0]  MaxCnt     = CNT_W'(MAX_PAGES);
    localparam logic [DCNT_W-1:0] FreeThresh = DCNT_W'(FREE_THRESHOLD);
    localparam int unsigned STREAK_W = (ALLOC_BURST > 0) ? $clog2(ALLOC_BURST + 1) : 1;
    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(ALLOC_BURST);
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SettleLast =
        SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit SettleEn = (SETTLE_CYCLES > 0);

    typedef enum logic [2:0] {
        StIdle, StAFetch, StACheck, StFFetch, StFCheck, StFSettle
    } state_e;

    state_e               state_q, state_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic                 last_alloc_q, last_alloc_d;
    logic                 settle_pend_q, settle_pend_d;

    logic [ID_W-1:0]      f_pend_id_q;
    logic [IDX_W-1:0]     f_pend_idx_q;
    logic [SZ_W-1:0]      f_pend_sz_q;

    logic elig_a, elig_f;
    logic a_zero, a_over, f_zero, f_over;
    logic a_issue, a_fail, f_issue, f_park, f_fire, f_fail;

    // Size class is ceil(log2(c)): one past the MSB position of c-1.
    function automatic logic [SZ_W-1:0] size_class(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] m;
        logic [SZ_W-1:0]  s;
        m = cnt - CNT_W'(1);
        s = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (m[i]) s = SZ_W'(i + 1);
        end
        return s;
    endfunction

    assign elig_a = !alloc_fifo_empty && !alloc_rsp_fifo_almost_full && !fdt_blocked_fdt_in;
    assign elig_f = !free_fifo_empty && !free_rsp_fifo_almost_full;
    assign a_zero = (alloc_req_page_count == '0);
    assign a_over = (alloc_req_page_count > MaxCnt);
    assign f_zero = (free_req_page_count == '0);
    assign f_over = (free_req_page_count > MaxCnt);
    assign busy   = (state_q != StIdle);

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        settle_cnt_d  = settle_cnt_q;
        last_alloc_d  = last_alloc_q;
        settle_pend_d = settle_pend_q;
        alloc_req_pop = 1'b0;
        free_req_pop  = 1'b0;
        a_issue       = 1'b0;
        a_fail        = 1'b0;
        f_issue       = 1'b0;
        f_park        = 1'b0;
        f_fire        = 1'b0;
        f_fail        = 1'b0;
        case (state_q)
            StIdle: begin
                if (elig_f && ((free_fifo_data_count >= FreeThresh) ||
                               (streak_q >= StreakMax) || !elig_a)) begin
                    state_d = StFFetch;
                end else if (elig_a) begin
                    state_d = StAFetch;
                end
            end
            StAFetch: begin
                alloc_req_pop = 1'b1;
                last_alloc_d  = 1'b1;
                if (streak_q != StreakMax) streak_d = streak_q + STREAK_W'(1);
                state_d = StACheck;
            end
            StACheck: begin
                if (a_zero || a_over) a_fail = 1'b1;
                else                  a_issue = 1'b1;
                state_d = StIdle;
            end
            StFFetch: begin
                free_req_pop = 1'b1;
                // Remember whether this free follows an alloc before the flag is overwritten.
                settle_pend_d = last_alloc_q && SettleEn;
                last_alloc_d  = 1'b0;
                streak_d      = '0;
                state_d       = StFCheck;
            end
            StFCheck: begin
                if (f_zero || f_over) begin
                    f_fail  = 1'b1;
                    state_d = StIdle;
                end else if (settle_pend_q) begin
                    f_park  = 1'b1;
                    state_d = StFSettle;
                end else begin
                    f_issue = 1'b1;
                    state_d = StIdle;
                end
            end
            StFSettle: begin
                if (settle_cnt_q == SettleLast) begin
                    f_fire       = 1'b1;
                    settle_cnt_d = '0;
                    state_d      = StIdle;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            streak_q      <= '0;
            settle_cnt_q  <= '0;
            last_alloc_q  <= 1'b0;
            settle_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            settle_cnt_q  <= settle_cnt_d;
            last_alloc_q  <= last_alloc_d;
            settle_pend_q <= settle_pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_req_valid_fdt_out       <= 1'b0;
            alloc_req_id_fdt_out          <= '0;
            alloc_req_size_fdt_out        <= '0;
            free_req_valid_or_tree_out    <= 1'b0;
            free_req_id_or_tree_out       <= '0;
            free_req_page_idx_or_tree_out <= '0;
            free_req_size_or_tree_out     <= '0;
            alloc_rsp_write_en            <= 1'b0;
            alloc_rsp_id                  <= '0;
            alloc_rsp_fail                <= 1'b0;
            alloc_rsp_fail_reason         <= '0;
            free_rsp_write_en             <= 1'b0;
            free_rsp_id                   <= '0;
            free_rsp_fail                 <= 1'b0;
            free_rsp_fail_reason          <= '0;
            f_pend_id_q                   <= '0;
            f_pend_idx_q                  <= '0;
            f_pend_sz_q                   <= '0;
        end else begin
            alloc_req_valid_fdt_out <= a_issue;
            if (a_issue) begin
                alloc_req_id_fdt_out   <= alloc_req_id;
                alloc_req_size_fdt_out <= size_class(alloc_req_page_count);
            end
            alloc_rsp_write_en <= a_fail;
            alloc_rsp_fail     <= a_fail;
            if (a_fail) begin
                alloc_rsp_id          <= alloc_req_id;
                alloc_rsp_fail_reason <= a_zero ? 2'd1 : 2'd2;
            end

            // Settled frees park here so the visible issue fields only change with the pulse.
            if (f_park) begin
                f_pend_id_q  <= free_req_id;
                f_pend_idx_q <= free_req_page_idx;
                f_pend_sz_q  <= size_class(free_req_page_count);
            end
            free_req_valid_or_tree_out <= f_issue || f_fire;
            if (f_issue) begin
                free_req_id_or_tree_out       <= free_req_id;
                free_req_page_idx_or_tree_out <= free_req_page_idx;
                free_req_size_or_tree_out     <= size_class(free_req_page_count);
            end else if (f_fire) begin
                free_req_id_or_tree_out       <= f_pend_id_q;
                free_req_page_idx_or_tree_out <= f_pend_idx_q;
                free_req_size_or_tree_out     <= f_pend_sz_q;
            end
            free_rsp_write_en <= f_fail;
            free_rsp_fail     <= f_fail;
            if (f_fail) begin
                free_rsp_id          <= free_req_id;
                free_rsp_fail_reason <= f_zero ? 2'd1 : 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_req_dispatcher.sv
// Bench for req_dispatcher: FIFO models plus a queue-level reference of the dispatch policy,
// driven by directed scenarios and a randomized phase.
module tb_req_dispatcher;

    localparam int THR    = 4;
    localparam int BURST  = 2;
    localparam int SETTLE = 3;
    localparam int MAXP   = 8;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] idx;
        logic [7:0]  cnt;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req_pop, free_req_pop;
    logic [7:0]  alloc_req_id, alloc_req_page_count;
    logic        alloc_fifo_empty;
    logic [7:0]  free_req_id, free_req_page_count;
    logic [15:0] free_req_page_idx;
    logic        free_fifo_empty;
    logic [9:0]  free_fifo_data_count;
    logic        alloc_req_valid_fdt_out;
    logic [7:0]  alloc_req_id_fdt_out;
    logic [1:0]  alloc_req_size_fdt_out;
    logic        fdt_blocked_fdt_in;
    logic        free_req_valid_or_tree_out;
    logic [7:0]  free_req_id_or_tree_out;
    logic [15:0] free_req_page_idx_or_tree_out;
    logic [1:0]  free_req_size_or_tree_out;
    logic        alloc_rsp_write_en, alloc_rsp_fail;
    logic [7:0]  alloc_rsp_id;
    logic [1:0]  alloc_rsp_fail_reason;
    logic        alloc_rsp_fifo_almost_full;
    logic        free_rsp_write_en, free_rsp_fail;
    logic [7:0]  free_rsp_id;
    logic [1:0]  free_rsp_fail_reason;
    logic        free_rsp_fifo_almost_full;
    logic        busy;

    req_dispatcher #(
        .MAX_PAGES(MAXP), .FREE_THRESHOLD(THR), .ALLOC_BURST(BURST), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_req_pop(alloc_req_pop), .alloc_req_id(alloc_req_id),
        .alloc_req_page_count(alloc_req_page_count), .alloc_fifo_empty(alloc_fifo_empty),
        .free_req_pop(free_req_pop), .free_req_id(free_req_id),
        .free_req_page_idx(free_req_page_idx), .free_req_page_count(free_req_page_count),
        .free_fifo_empty(free_fifo_empty), .free_fifo_data_count(free_fifo_data_count),
        .alloc_req_valid_fdt_out(alloc_req_valid_fdt_out),
        .alloc_req_id_fdt_out(alloc_req_id_fdt_out),
        .alloc_req_size_fdt_out(alloc_req_size_fdt_out),
        .fdt_blocked_fdt_in(fdt_blocked_fdt_in),
        .free_req_valid_or_tree_out(free_req_valid_or_tree_out),
        .free_req_id_or_tree_out(free_req_id_or_tree_out),
        .free_req_page_idx_or_tree_out(free_req_page_idx_or_tree_out),
        .free_req_size_or_tree_out(free_req_size_or_tree_out),
        .alloc_rsp_write_en(alloc_rsp_write_en), .alloc_rsp_id(alloc_rsp_id),
        .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
        .alloc_rsp_fifo_almost_full(alloc_rsp_fifo_almost_full),
        .free_rsp_write_en(free_rsp_write_en), .free_rsp_id(free_rsp_id),
        .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason),
        .free_rsp_fifo_almost_full(free_rsp_fifo_almost_full),
        .busy(busy)
    );

    always #5 clk = ~clk;

    req_t        aq[$];
    req_t        fq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          streak   = 0;
    bit          last_alloc = 1'b0;
    bit          pend = 1'b0;
    int          pend_kind, pend_cyc;
    logic [7:0]  pend_id;
    logic [15:0] pend_idx;
    logic [1:0]  pend_sz, pend_reason;
    logic [1:0]  pop_seen;
    string       order = "";

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] size_of(input int c);
        int s = 0;
        while ((1 << s) < c) s++;
        return 2'(s);
    endfunction

    task automatic update_flags();
        alloc_fifo_empty     = (aq.size() == 0);
        free_fifo_empty      = (fq.size() == 0);
        free_fifo_data_count = 10'(fq.size());
    endtask

    task automatic push_alloc(input logic [7:0] id, input logic [7:0] cnt);
        req_t r;
        r.id = id; r.idx = '0; r.cnt = cnt;
        aq.push_back(r);
        update_flags();
    endtask

    task automatic push_free(input logic [7:0] id, input logic [15:0] idx, input logic [7:0] cnt);
        req_t r;
        r.id = id; r.idx = idx; r.cnt = cnt;
        fq.push_back(r);
        update_flags();
    endtask

    // kind: 0 alloc issue, 1 alloc response, 2 free issue, 3 free response
    task automatic expect_pulse(input int kind, input req_t r, input int lat);
        pend        = 1'b1;
        pend_kind   = kind;
        pend_cyc    = cyc + lat;
        pend_id     = r.id;
        pend_idx    = r.idx;
        pend_sz     = size_of(int'(r.cnt));
        pend_reason = (r.cnt == 0) ? 2'd1 : 2'd2;
    endtask

    task automatic tick();
        logic [3:0] pulses, exp_pulses;
        logic [1:0] want;
        bit ea, ef, wf, legal;
        req_t r;
        @(negedge clk);
        cyc++;
        pop_seen   = {free_req_pop, alloc_req_pop};
        pulses     = {free_rsp_write_en, free_req_valid_or_tree_out,
                      alloc_rsp_write_en, alloc_req_valid_fdt_out};
        exp_pulses = (pend && cyc == pend_cyc) ? 4'(1 << pend_kind) : 4'b0;
        check("pulses", 128'(pulses), 128'(exp_pulses));
        if (pend && cyc == pend_cyc) begin
            case (pend_kind)
                0: begin
                    check("fdt_id", 128'(alloc_req_id_fdt_out), 128'(pend_id));
                    check("fdt_size", 128'(alloc_req_size_fdt_out), 128'(pend_sz));
                end
                1: begin
                    check("arsp_id", 128'(alloc_rsp_id), 128'(pend_id));
                    check("arsp_fail", 128'(alloc_rsp_fail), 128'(1));
                    check("arsp_reason", 128'(alloc_rsp_fail_reason), 128'(pend_reason));
                end
                2: begin
                    check("ortree_id", 128'(free_req_id_or_tree_out), 128'(pend_id));
                    check("ortree_idx", 128'(free_req_page_idx_or_tree_out), 128'(pend_idx));
                    check("ortree_size", 128'(free_req_size_or_tree_out), 128'(pend_sz));
                end
                default: begin
                    check("frsp_id", 128'(free_rsp_id), 128'(pend_id));
                    check("frsp_fail", 128'(free_rsp_fail), 128'(1));
                    check("frsp_reason", 128'(free_rsp_fail_reason), 128'(pend_reason));
                end
            endcase
            pend = 1'b0;
        end else if (pend && cyc < pend_cyc) begin
            check("busy_in_flight", 128'(busy), 128'(1));
        end
        if (pop_seen != 2'b00) begin
            // Inputs and queues are unchanged since the decision edge, so they are what it saw.
            ea   = (aq.size() > 0) && !alloc_rsp_fifo_almost_full && !fdt_blocked_fdt_in;
            ef   = (fq.size() > 0) && !free_rsp_fifo_almost_full;
            wf   = ef && ((fq.size() >= THR) || (streak >= BURST) || !ea);
            want = wf ? 2'b10 : (ea ? 2'b01 : 2'b00);
            check("pop_kind", 128'(pop_seen), 128'(want));
            check("single_in_flight", 128'(pend), 128'(0));
            if (alloc_req_pop && aq.size() > 0) begin
                r = aq.pop_front();
                alloc_req_id = r.id;
                alloc_req_page_count = r.cnt;
                order = {order, "A"};
                if (streak < 1000) streak++;
                legal = (r.cnt != 0) && (r.cnt <= MAXP);
                expect_pulse(legal ? 0 : 1, r, 2);
                last_alloc = 1'b1;
            end else if (free_req_pop && fq.size() > 0) begin
                r = fq.pop_front();
                free_req_id = r.id;
                free_req_page_idx = r.idx;
                free_req_page_count = r.cnt;
                order = {order, "F"};
                streak = 0;
                legal = (r.cnt != 0) && (r.cnt <= MAXP);
                if (legal) expect_pulse(2, r, last_alloc ? 2 + SETTLE : 2);
                else       expect_pulse(3, r, 2);
                last_alloc = 1'b0;
            end
            update_flags();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, 128'({alloc_req_pop, free_req_pop, alloc_req_valid_fdt_out,
                         alloc_req_id_fdt_out, alloc_req_size_fdt_out,
                         free_req_valid_or_tree_out, free_req_id_or_tree_out,
                         free_req_page_idx_or_tree_out, free_req_size_or_tree_out,
                         alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_fail, alloc_rsp_fail_reason,
                         free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
                         busy}), 128'(0));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_outputs_zero(tag);
        pend = 1'b0; streak = 0; last_alloc = 1'b0;
        aq.delete(); fq.delete();
        update_flags();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((aq.size() != 0 || fq.size() != 0 || pend) && i < 400) begin
            tick();
            i++;
        end
        check(tag, 128'({aq.size() != 0, fq.size() != 0, pend}), 128'(0));
        repeat (3) tick();
    endtask

    task automatic wait_pop(input logic [1:0] kind, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (pop_seen == kind) got = 1'b1;
        end
        check("wait_pop", 128'(got), 128'(1));
    endtask

    initial begin
        rst = 1'b1;
        alloc_req_id = '0; alloc_req_page_count = '0;
        free_req_id = '0; free_req_page_idx = '0; free_req_page_count = '0;
        fdt_blocked_fdt_in = 1'b0;
        alloc_rsp_fifo_almost_full = 1'b0;
        free_rsp_fifo_almost_full = 1'b0;
        update_flags();
        #1;
        check_outputs_zero("reset_state");
        repeat (2) tick();

        // Single legal alloc; first decision right after reset release.
        push_alloc(8'd5, 8'd3);
        rst = 1'b0;
        tick();
        check("first_dispatch", 128'(pop_seen), 128'(2'b01));
        drain("drain_single_alloc");
        check("held_fdt_id", 128'(alloc_req_id_fdt_out), 128'(8'd5));
        check("held_fdt_size", 128'(alloc_req_size_fdt_out), 128'(2'd2));

        // Zero and oversize alloc counts.
        push_alloc(8'd7, 8'd0);
        push_alloc(8'd8, 8'd9);
        drain("drain_bad_allocs");

        // Burst interleave with settle on every free.
        do_reset("reset_before_burst");
        order = "";
        for (int i = 0; i < 6; i++) push_alloc(8'(16 + i), 8'(1 + i));
        for (int i = 0; i < 3; i++) push_free(8'(32 + i), 16'(100 * i + 7), 8'(2 * i + 2));
        drain("drain_burst");
        check("burst_order", 128'(order == "AAFAAFAAF"), 128'(1));

        // Blocked fdt with no frees: nothing moves; a free then goes through without settle.
        do_reset("reset_before_blocked");
        fdt_blocked_fdt_in = 1'b1;
        push_alloc(8'h41, 8'd2);
        push_alloc(8'h42, 8'd8);
        repeat (6) tick();
        check("blocked_idle", 128'(busy), 128'(0));
        check("blocked_no_pop", 128'(aq.size()), 128'(2));
        push_free(8'h40, 16'h0055, 8'd4);
        wait_pop(2'b10, 10);
        repeat (4) tick();
        check("blocked_free_done", 128'(pend), 128'(0));
        fdt_blocked_fdt_in = 1'b0;
        drain("drain_blocked");

        // Free queue at threshold wins over queued allocs.
        do_reset("reset_before_threshold");
        order = "";
        for (int i = 0; i < 3; i++) push_alloc(8'(80 + i), 8'(5 + i));
        for (int i = 0; i < 4; i++) push_free(8'(90 + i), 16'(16'h1000 + i), 8'(1 + i));
        drain("drain_threshold");
        check("threshold_first_free", 128'(order.len() > 0 ? order[0] : 8'h00), 128'(8'h46));

        // Reset in the middle of a settle: nothing may surface afterwards.
        do_reset("reset_before_settle");
        push_alloc(8'd20, 8'd1);
        drain("drain_pre_settle");
        push_free(8'd30, 16'h1234, 8'd2);
        wait_pop(2'b10, 10);
        repeat (2) tick();
        check("in_settle_busy", 128'(busy), 128'(1));
        do_reset("reset_mid_settle");
        repeat (10) tick();

        // Randomized traffic with random backpressure.
        do_reset("reset_before_random");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                push_alloc(8'($urandom), 8'($urandom_range(0, 10)));
            if ($urandom_range(0, 3) == 0)
                push_free(8'($urandom), 16'($urandom), 8'($urandom_range(0, 10)));
            fdt_blocked_fdt_in         = ($urandom_range(0, 7) == 0);
            alloc_rsp_fifo_almost_full = ($urandom_range(0, 9) == 0);
            free_rsp_fifo_almost_full  = ($urandom_range(0, 9) == 0);
            tick();
        end
        fdt_blocked_fdt_in = 1'b0;
        alloc_rsp_fifo_almost_full = 1'b0;
        free_rsp_fifo_almost_full = 1'b0;
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of its sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
